// File: rtl/game_pkg.sv
// Shared definitions for the rally game controller: state codes, default
// match parameters and the score-to-display packing.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam int WIN_SCORE_DEF   = 5;
    localparam int SERVE_DELAY_DEF = 3;
    localparam int POINT_HOLD_DEF  = 8;

    // Two decimal digit pairs for the 4-digit display: s1 on the left, s2 on the right.
    function automatic logic [13:0] score_disp(input logic [3:0] s1, input logic [3:0] s2);
        return (14'(s1) * 14'd100) + 14'(s2);
    endfunction

endpackage

// File: rtl/game_tick_timer.sv
// Counts tick strobes since the last clear; done fires on the tick that
// reaches the terminal count, so the caller can move on that same edge.
module game_tick_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] tc,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = tick && (((W+1)'(cnt) + (W+1)'(1)) == (W+1)'(tc));

    // Saturate so a long stay in a state that ignores the timer cannot wrap.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (tick && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/rally_ctrl.sv
// Match controller for a two-bar ball game: serve delay, rally, point hold,
// scoring and game-over, with every output driven straight from a flop.
module rally_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int SERVE_DELAY = SERVE_DELAY_DEF,
    parameter int POINT_HOLD  = POINT_HOLD_DEF
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic        tick,
    input  logic        miss_p1,
    input  logic        miss_p2,
    output logic        ball_en,
    output logic        ball_load,
    output logic        serve_side,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic [1:0]  winner,
    output logic [2:0]  state,
    output logic [13:0] disp_value
);

    localparam int         TMAX = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int         TW   = $clog2(TMAX + 1);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);

    game_state_t st, st_n;
    logic        start_q, start_rise;
    logic        any_miss, pt1, pt2;
    logic [3:0]  s1_n, s2_n;
    logic        side_n;
    logic [1:0]  win_n;
    logic [TW-1:0] tc;
    logic        t_done, t_tick, enter;

    assign start_rise = start & ~start_q;
    assign any_miss   = miss_p1 | miss_p2;
    assign pt1        = miss_p2 & ~miss_p1;
    assign pt2        = miss_p1 & ~miss_p2;
    assign enter      = (st_n != st);
    // A tick landing on the scoring edge belongs to the rally, not the hold.
    assign t_tick     = tick & ~((st == ST_RALLY) & any_miss);
    assign state      = st;

    game_tick_timer #(.W(TW)) u_timer (
        .CLK  (CLK),
        .RSTn (RSTn),
        .clr  (enter),
        .tick (t_tick),
        .tc   (tc),
        .done (t_done)
    );

    always_comb begin
        st_n   = st;
        s1_n   = score1;
        s2_n   = score2;
        side_n = serve_side;
        win_n  = winner;
        tc     = TW'(SERVE_DELAY);
        case (st)
            ST_IDLE: begin
                if (start_rise) st_n = ST_SERVE;
            end
            ST_SERVE: begin
                if (t_done) st_n = ST_RALLY;
            end
            ST_RALLY: begin
                if (any_miss) st_n = ST_POINT;
                if (pt1) begin
                    side_n = 1'b1;
                    if (score1 != WIN) s1_n = score1 + 4'd1;
                end
                if (pt2) begin
                    side_n = 1'b0;
                    if (score2 != WIN) s2_n = score2 + 4'd1;
                end
            end
            ST_POINT: begin
                tc = TW'(POINT_HOLD);
                if (t_done) begin
                    if ((score1 == WIN) || (score2 == WIN)) begin
                        st_n  = ST_OVER;
                        win_n = (score1 == WIN) ? 2'd1 : 2'd2;
                    end else begin
                        st_n = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    st_n   = ST_SERVE;
                    s1_n   = 4'd0;
                    s2_n   = 4'd0;
                    win_n  = 2'd0;
                    side_n = 1'b0;
                end
            end
            default: st_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            st         <= ST_IDLE;
            start_q    <= 1'b0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            serve_side <= 1'b0;
            winner     <= 2'd0;
            ball_en    <= 1'b0;
            ball_load  <= 1'b0;
            disp_value <= 14'd0;
        end else begin
            st         <= st_n;
            start_q    <= start;
            score1     <= s1_n;
            score2     <= s2_n;
            serve_side <= side_n;
            winner     <= win_n;
            ball_en    <= (st_n == ST_RALLY);
            ball_load  <= enter && (st_n == ST_SERVE);
            disp_value <= score_disp(score1, score2);
        end
    end

endmodule

// File: tb/tb_rally_ctrl.sv
// Bench for rally_ctrl: directed match scenarios plus random play, all
// checked every cycle against a behavioural model of the game rules.
module tb_rally_ctrl;

    localparam int WS = 3;
    localparam int SD = 2;
    localparam int PH = 2;

    logic        CLK = 1'b0;
    logic        RSTn, start, tick, miss_p1, miss_p2;
    logic        ball_en, ball_load, serve_side;
    logic [3:0]  score1, score2;
    logic [1:0]  winner;
    logic [2:0]  state;
    logic [13:0] disp_value;

    rally_ctrl #(.WIN_SCORE(WS), .SERVE_DELAY(SD), .POINT_HOLD(PH)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .start      (start),
        .tick       (tick),
        .miss_p1    (miss_p1),
        .miss_p2    (miss_p2),
        .ball_en    (ball_en),
        .ball_load  (ball_load),
        .serve_side (serve_side),
        .score1     (score1),
        .score2     (score2),
        .winner     (winner),
        .state      (state),
        .disp_value (disp_value)
    );

    always #5 CLK = ~CLK;

    int nvec = 0, ncmp = 0, nerr = 0;
    bit chk_on = 1'b0;

    // Model of the match: phase 0 idle, 1 serving, 2 rally, 3 point hold, 4 over.
    int m_st, m_s1, m_s2, m_win, m_side, m_load, m_en, m_disp, m_cnt, m_ps;

    task automatic model_reset();
        m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_side = 0;
        m_load = 0; m_en = 0; m_disp = 0; m_cnt = 0; m_ps = 0;
    endtask

    task automatic model_step();
        bit rise;
        int np;
        rise   = (start == 1'b1) && (m_ps == 0);
        m_ps   = int'(start);
        m_disp = m_s1 * 100 + m_s2;
        np     = m_st;
        if (m_st == 0) begin
            if (rise) np = 1;
        end else if (m_st == 1) begin
            if (tick) m_cnt++;
            if (m_cnt == SD) np = 2;
        end else if (m_st == 2) begin
            if (miss_p1 || miss_p2) np = 3;
            if (miss_p1 && !miss_p2) begin m_s2++; m_side = 0; end
            if (miss_p2 && !miss_p1) begin m_s1++; m_side = 1; end
        end else if (m_st == 3) begin
            if (tick) m_cnt++;
            if (m_cnt == PH) begin
                if (m_s1 == WS)      begin np = 4; m_win = 1; end
                else if (m_s2 == WS) begin np = 4; m_win = 2; end
                else np = 1;
            end
        end else begin
            if (rise) begin
                np = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_side = 0;
            end
        end
        m_load = (np == 1 && m_st != 1) ? 1 : 0;
        if (np != m_st) m_cnt = 0;
        m_st = np;
        m_en = (np == 2) ? 1 : 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        ncmp++;
        if (act !== 32'(exp)) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("model.state",      32'(state),      m_st);
            chk("model.ball_en",    32'(ball_en),    m_en);
            chk("model.ball_load",  32'(ball_load),  m_load);
            chk("model.serve_side", 32'(serve_side), m_side);
            chk("model.score1",     32'(score1),     m_s1);
            chk("model.score2",     32'(score2),     m_s2);
            chk("model.winner",     32'(winner),     m_win);
            chk("model.disp_value", 32'(disp_value), m_disp);
        end
    end

    task automatic expect_out(input string nm, input int st, input int en, input int ld,
                              input int sd, input int s1, input int s2, input int w, input int d);
        chk({nm, ".state"},      32'(state),      st);
        chk({nm, ".ball_en"},    32'(ball_en),    en);
        chk({nm, ".ball_load"},  32'(ball_load),  ld);
        chk({nm, ".serve_side"}, 32'(serve_side), sd);
        chk({nm, ".score1"},     32'(score1),     s1);
        chk({nm, ".score2"},     32'(score2),     s2);
        chk({nm, ".winner"},     32'(winner),     w);
        chk({nm, ".disp_value"}, 32'(disp_value), d);
    endtask

    task automatic cyc(input logic s, input logic t, input logic a, input logic b);
        @(negedge CLK);
        #1;
        RSTn = 1'b1; start = s; tick = t; miss_p1 = a; miss_p2 = b;
        model_step();
        nvec++;
        @(posedge CLK);
        #1;
    endtask

    task automatic async_reset();
        RSTn = 1'b0;
        start = 1'b0; tick = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        RSTn = 1'b0; start = 1'b0; tick = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0;
        model_reset();
        #2;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk_on = 1'b1;

        // Start, serve delay, first point to player 1
        cyc(1, 0, 0, 0); expect_out("serve_entry", 1, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_out("serve_hold",  1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0); expect_out("serve_tick1", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0); expect_out("rally",       2, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1); expect_out("pt_to_p1",    3, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0); expect_out("reserve",     1, 0, 1, 1, 1, 0, 0, 100);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0); expect_out("rally2",      2, 1, 0, 1, 1, 0, 0, 100);

        // Double miss with a coincident tick: no score, tick not counted
        cyc(0, 1, 1, 1); expect_out("both_miss",   3, 0, 0, 1, 1, 0, 0, 100);
        cyc(0, 1, 0, 0); expect_out("tick_w_miss", 3, 0, 0, 1, 1, 0, 0, 100);
        cyc(0, 1, 0, 0); expect_out("hold_done",   1, 0, 1, 1, 1, 0, 0, 100);

        // Ignored inputs: miss in SERVE, start rise in RALLY
        cyc(0, 0, 1, 0); expect_out("serve_miss",  1, 0, 0, 1, 1, 0, 0, 100);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0); expect_out("rally_start", 2, 1, 0, 1, 1, 0, 0, 100);
        cyc(0, 0, 0, 1); expect_out("pt_to_p1_b",  3, 0, 0, 1, 2, 0, 0, 100);

        // Asynchronous reset mid-point
        async_reset();
        expect_out("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1); expect_out("idle_miss",   0, 0, 0, 0, 0, 0, 0, 0);

        // Player 2 wins 3-0
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int p = 0; p < 3; p++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 1, 0, 0);
            cyc(0, 1, 0, 0);
            if (p < 2) begin
                cyc(0, 1, 0, 0);
                cyc(0, 1, 0, 0);
            end
        end
        expect_out("over",      4, 0, 0, 0, 0, 3, 2, 3);
        cyc(0, 1, 1, 0); expect_out("over_miss", 4, 0, 0, 0, 0, 3, 2, 3);
        cyc(1, 0, 0, 0); expect_out("restart",   1, 0, 1, 0, 0, 0, 0, 3);
        cyc(1, 0, 0, 0); expect_out("restart_d", 1, 0, 0, 0, 0, 0, 0, 0);

        // Random play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
                expect_out("rnd_rst", 0, 0, 0, 0, 0, 0, 0, 0);
            end
            cyc(($urandom_range(0, 3) == 0) ? ~start : start,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 6) == 0));
        end

        @(negedge CLK);
        #1;
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rally_ctrl.md
RALLY_CTRL -- requirements
Module: rally_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, meaning points needed to win a match (legal range 1..9).
REQ-002 SHALL have parameter SERVE_DELAY, default 3, meaning number of tick strobes the ball is held before a serve.
REQ-003 SHALL have parameter POINT_HOLD, default 8, meaning number of tick strobes the ball is frozen after a point.
REQ-004 CLK  input  1  system clock; one clock; reset is asynchronous and active-low.
REQ-005 RSTn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  debounced start button, level; only the rising edge is used.
REQ-007 tick  input  1  one-cycle ball-step strobe from the ball prescaler.
REQ-008 miss_p1  input  1  one-cycle pulse: ball passed bar 1 (point to player 2).
REQ-009 miss_p2  input  1  one-cycle pulse: ball passed bar 2 (point to player 1).
REQ-010 ball_en  output  1  ball datapath may advance on tick.
REQ-011 ball_load  output  1  one-cycle pulse: reposition ball onto the serving bar.
REQ-012 serve_side  output  1  serving player: 0 = bar 1, 1 = bar 2.
REQ-013 score1, score2  output  4 each  player points.
REQ-014 winner  output  2  0 = none, 1 = player 1, 2 = player 2.
REQ-015 state  output  3  FSM state code.
REQ-016 disp_value  output  14  score1*100 + score2, to the BIN14to7SEG4 display.

Function
REQ-017 FSM states SHALL be IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4; all outputs SHALL be registered.
REQ-018 Start rise SHALL be start=1 with the previous-cycle sample 0; the transition SHALL occur on that same edge.
REQ-019 IDLE SHALL go to SERVE on a start rise.
REQ-020 ball_load SHALL be 1 in exactly the first cycle of every SERVE entry.
REQ-021 On every state entry, the internal tick counter SHALL clear; it SHALL count tick pulses only.
REQ-022 SERVE SHALL go to RALLY on the clock edge of the SERVE_DELAY-th tick; ball_en SHALL be 0 in SERVE.
REQ-023 ball_en SHALL be 1 exactly while the state is RALLY.
REQ-024 In RALLY, miss_p1 alone SHALL increment score2, set serve_side=0, and enter POINT on the same edge.
REQ-025 In RALLY, miss_p2 alone SHALL increment score1, set serve_side=1, and enter POINT on the same edge.
REQ-026 In RALLY, simultaneous miss_p1 and miss_p2 SHALL score nothing, leave serve_side unchanged, and enter POINT.
REQ-027 miss_p1/miss_p2 outside RALLY, and start rises outside IDLE/OVER, SHALL be ignored.
REQ-028 POINT SHALL end on the POINT_HOLD-th tick, going to OVER if either score equals WIN_SCORE, otherwise to SERVE.
REQ-029 On OVER entry, winner SHALL be set to the player whose score equals WIN_SCORE.
REQ-030 A start rise in OVER SHALL clear scores, winner and serve_side, and enter SERVE.
REQ-031 Scores SHALL never exceed WIN_SCORE.
REQ-032 disp_value SHALL update one cycle after any score change, computed in 14 bits with no overflow (max 909).
REQ-033 A tick coinciding with a miss in RALLY SHALL NOT be counted toward POINT_HOLD.

Reset
REQ-034 While RSTn=0, the outputs SHALL be: state=IDLE, ball_en=0, ball_load=0, serve_side=0, score1=score2=0, winner=0, disp_value=0; the tick counter and start sample SHALL be 0.
REQ-035 Reset assertion mid-operation (any state) SHALL take effect immediately without waiting for CLK; after release, a start rise is required.

Structure
REQ-036 State codes and the WIN_SCORE/SERVE_DELAY/POINT_HOLD defaults SHALL live in the shared game package, game_pkg.
REQ-037 The tick counter with clear-on-entry and terminal-count compare SHALL be a sub-module, game_tick_timer.

Verification (WIN_SCORE=3, SERVE_DELAY=2, POINT_HOLD=2)
REQ-038 Reset, start rise -> next cycle state=1 and ball_load=1 for exactly one cycle; 2 ticks -> state=2, ball_en=1.
REQ-039 In RALLY, miss_p2 pulse -> score1=1, serve_side=1, state=3, ball_en=0; 2 ticks -> state=1 plus a ball_load pulse; disp_value=100.
REQ-040 Same-cycle miss_p1 and miss_p2 -> scores unchanged, state=3, serve_side unchanged.
REQ-041 Three miss_p1 points -> score2=3, after hold state=4, winner=2, disp_value=3; misses now ignored; start rise -> scores=0, winner=0, state=1.
REQ-042 Misses in IDLE/SERVE and start rise in RALLY -> no state or score change.
REQ-043 RSTn pulsed low in POINT with score1=2 -> all outputs at reset values before the next CLK edge.
